// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction memory geometry
// and the program loader's state encoding.
package cpu_pkg;

  localparam int IMEM_WORDS = 128;
  localparam int INSTR_W    = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CHK,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Program loader: takes a framed byte stream (length, big-endian words,
// XOR checksum), writes the words into instruction memory and keeps the
// CPU in reset until a complete image has been verified.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int MAX_WORDS = IMEM_WORDS,
  parameter int AW        = $clog2(MAX_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [AW-1:0]      imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  localparam logic [8:0]  MAX_LEN = 9'(MAX_WORDS);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  loader_state_e      state_q;
  logic [AW:0]        len_q;
  logic [AW:0]        wordCnt_q;
  logic [AW:0]        wordCntInc;
  logic [7:0]         csum_q;
  logic [7:0]         hiByte_q;
  logic               in_ready_q;
  logic               imem_we_q;
  logic [AW-1:0]      imem_waddr_q;
  logic [INSTR_W-1:0] imem_wdata_q;
  logic               cpu_reset_q;
  logic               done_q;
  logic               error_q;
  logic               accept;

  // A byte moves only when the source offers it and we advertised readiness.
  assign accept     = in_valid && in_ready_q;
  // The word counter is one bit wider than the address so a full image
  // of MAX_WORDS words can be compared against its length without wrapping.
  assign wordCntInc = wordCnt_q + CNT_ONE;

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

  // Frame parser, imem write port and CPU reset control, all registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      wordCnt_q    <= '0;
      csum_q       <= '0;
      hiByte_q     <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q     <= LEN;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wordCnt_q   <= '0;
            csum_q      <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            if (in_data == 8'd0) begin
              state_q <= CHK;
            end else if ({1'b0, in_data} > MAX_LEN) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              len_q     <= (AW+1)'(in_data);
              wordCnt_q <= '0;
              csum_q    <= '0;
              state_q   <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            hiByte_q <= in_data;
            csum_q   <= csum_q ^ in_data;
            state_q  <= LO;
          end
        end
        LO: begin
          if (accept) begin
            csum_q       <= csum_q ^ in_data;
            imem_we_q    <= 1'b1;
            imem_waddr_q <= wordCnt_q[AW-1:0];
            imem_wdata_q <= {hiByte_q, in_data};
            wordCnt_q    <= wordCntInc;
            state_q      <= (wordCntInc == len_q) ? CHK : HI;
          end
        end
        CHK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level reference model
// predicts every imem write (with its cycle), the handshake and the
// done/error/cpu_reset levels; a compare process checks them every cycle.
module tb_imem_loader;
  import cpu_pkg::*;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    int          cyc;
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [6:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  wr_t         expWr[$];
  wr_t         actWr[$];
  logic [7:0]  got[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rdIdx = 0;
  int          expOut = 0;
  logic        expRdy = 1'b0;
  logic [6:0]  lastAddr = '0;
  logic [15:0] lastData = '0;
  bit          rstPend = 1'b1;

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Cycle stamp used to pin the exact cycle of each expected write.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every cycle: imem write port against the model, plus handshake and status levels.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      rstPend = 1'b1;
    end else begin
      if (rstPend) begin
        lastAddr = '0;
        lastData = '0;
        rstPend  = 1'b0;
      end
      if (imem_we === 1'b1) actWr.push_back('{cyc, imem_waddr, imem_wdata});
      if (rdIdx < expWr.size() && expWr[rdIdx].cyc == cyc) begin
        checkOutput("imem_we_pulse", 32'(imem_we), 32'd1);
        checkOutput("imem_waddr", 32'(imem_waddr), 32'(expWr[rdIdx].a));
        checkOutput("imem_wdata", 32'(imem_wdata), 32'(expWr[rdIdx].d));
        lastAddr = expWr[rdIdx].a;
        lastData = expWr[rdIdx].d;
        rdIdx++;
      end else begin
        checkOutput("imem_we_quiet", 32'(imem_we), 32'd0);
        checkOutput("waddr_hold", 32'(imem_waddr), 32'(lastAddr));
        checkOutput("wdata_hold", 32'(imem_wdata), 32'(lastData));
      end
      checkOutput("in_ready", 32'(in_ready), 32'(expRdy));
      checkOutput("done", 32'(done), 32'(expOut == 1));
      checkOutput("error", 32'(error), 32'(expOut == 2));
      checkOutput("cpu_reset", 32'(cpu_reset), 32'(expOut != 1));
    end
  end

  // Frame-level model: position p of the accepted byte decides its meaning.
  task automatic modelStep(input logic [7:0] b);
    int         p;
    int         n;
    logic [7:0] x;
    got.push_back(b);
    p = got.size() - 1;
    n = int'(got[0]);
    if (p == 0) begin
      if (n > IMEM_WORDS) begin
        expOut = 2;
        expRdy = 1'b0;
      end
    end else if (p % 2 == 0 && p <= 2 * n) begin
      expWr.push_back('{cyc, 7'(p / 2 - 1), {got[p-1], got[p]}});
    end else if (p == 2 * n + 1) begin
      x = 8'h00;
      for (int i = 1; i <= 2 * n; i++) x ^= got[i];
      expOut = (got[p] == x) ? 1 : 2;
      expRdy = 1'b0;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got.delete();
    expOut = 0;
    expRdy = 1'b1;
  endtask

  task automatic doReset(input int n);
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete();
    expOut = 0;
    expRdy = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
    checkOutput("rst_waddr", 32'(imem_waddr), 32'd0);
    checkOutput("rst_wdata", 32'(imem_wdata), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
  endtask

  // Offer one byte after an idle gap (garbage data, optional ignored start pulse).
  task automatic sendByte(input logic [7:0] b, input int gap, input bit poke, output bit ok);
    ok = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_data = 8'($urandom);
      start   = poke && (g == 0);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (ok) modelStep(b);
    else checkOutput("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input byteQ_t fr, input int gapMin, input int gapMax, input bit pokes);
    bit ok;
    pulseStart();
    foreach (fr[i]) begin
      if (!expRdy) break;
      sendByte(fr[i], $urandom_range(gapMax, gapMin), pokes && ($urandom_range(3, 0) == 0), ok);
      if (!ok) break;
    end
    checkOutput("frame_bytes_taken", 32'(got.size()), 32'(fr.size()));
    in_valid = 1'b1;
    repeat (4) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int     base;
    bit     ok;
    byteQ_t fr;
    int     n;
    logic [7:0] x;

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    doReset(2);

    // Normal load
    base = actWr.size();
    applyStimulus('{8'h02, 8'h00, 8'h01, 8'hB0, 8'h00, 8'hB1}, 0, 0, 1'b0);
    checkOutput("s1_write_count", 32'(actWr.size() - base), 32'd2);
    if (actWr.size() - base == 2) begin
      checkOutput("s1_w0_addr", 32'(actWr[base].a), 32'd0);
      checkOutput("s1_w0_data", 32'(actWr[base].d), 32'h0001);
      checkOutput("s1_w1_addr", 32'(actWr[base+1].a), 32'd1);
      checkOutput("s1_w1_data", 32'(actWr[base+1].d), 32'hB000);
    end
    checkOutput("s1_done", 32'(done), 32'd1);
    checkOutput("s1_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("s1_error", 32'(error), 32'd0);

    // Checksum fault
    base = actWr.size();
    applyStimulus('{8'h02, 8'h00, 8'h01, 8'hB0, 8'h00, 8'hB0}, 0, 0, 1'b0);
    checkOutput("s2_write_count", 32'(actWr.size() - base), 32'd2);
    checkOutput("s2_error", 32'(error), 32'd1);
    checkOutput("s2_done", 32'(done), 32'd0);
    checkOutput("s2_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("s2_in_ready", 32'(in_ready), 32'd0);

    // Oversized length, then zero length
    base = actWr.size();
    applyStimulus('{8'h81}, 0, 0, 1'b0);
    checkOutput("s3_len_writes", 32'(actWr.size() - base), 32'd0);
    checkOutput("s3_len_error", 32'(error), 32'd1);
    applyStimulus('{8'h00, 8'h00}, 0, 0, 1'b0);
    checkOutput("s3_zero_writes", 32'(actWr.size() - base), 32'd0);
    checkOutput("s3_zero_done", 32'(done), 32'd1);

    // Stalled source with ignored start pulses in the gaps
    base = actWr.size();
    applyStimulus('{8'h02, 8'h00, 8'h01, 8'hB0, 8'h00, 8'hB1}, 3, 3, 1'b1);
    checkOutput("s4_write_count", 32'(actWr.size() - base), 32'd2);
    checkOutput("s4_done", 32'(done), 32'd1);

    // Reset in the middle of a frame, then a clean 3-word load
    pulseStart();
    fr = '{8'h03, 8'h80, 8'h00, 8'h10};
    foreach (fr[i]) sendByte(fr[i], 0, 1'b0, ok);
    doReset(1);
    base = actWr.size();
    applyStimulus('{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E}, 0, 1, 1'b0);
    checkOutput("s5_write_count", 32'(actWr.size() - base), 32'd3);
    checkOutput("s5_done", 32'(done), 32'd1);
    if (actWr.size() - base == 3) begin
      checkOutput("s5_last_addr", 32'(actWr[base+2].a), 32'd2);
      checkOutput("s5_last_data", 32'(actWr[base+2].d), 32'h9ABC);
    end

    // Full depth, then restart from DONE
    fr = '{8'h80};
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    fr.push_back(8'h00);
    base = actWr.size();
    applyStimulus(fr, 0, 0, 1'b0);
    checkOutput("s6_write_count", 32'(actWr.size() - base), 32'd128);
    checkOutput("s6_last_addr", 32'(actWr[actWr.size()-1].a), 32'd127);
    checkOutput("s6_last_data", 32'(actWr[actWr.size()-1].d), 32'hFEFF);
    checkOutput("s6_done", 32'(done), 32'd1);
    pulseStart();
    checkOutput("s6_restart_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("s6_restart_done", 32'(done), 32'd0);
    fr = '{8'h01, 8'hAA, 8'h55, 8'hFF};
    foreach (fr[i]) sendByte(fr[i], 0, 1'b0, ok);
    checkOutput("s6_reload_done", 32'(done), 32'd1);

    // Randomized frames: lengths, contents, checksum faults, gaps, resets
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(5, 0) == 0) doReset($urandom_range(2, 1));
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = 129 + $urandom_range(126, 0);
        default: n = $urandom_range(12, 1);
      endcase
      fr = '{8'(n)};
      if (n <= IMEM_WORDS) begin
        x = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
          fr.push_back(8'($urandom));
          x ^= fr[i+1];
        end
        if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
        fr.push_back(x);
      end
      applyStimulus(fr, 0, 3, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("all_writes_seen", 32'(rdIdx), 32'(expWr.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writes a program image into the CPU's 16-bit instruction memory. It sits between a byte-stream source (host or UART receiver) and the imem write port. The image is a framed byte stream: length, big-endian instruction words, then an XOR checksum. The block holds the CPU in reset until a complete image with a valid checksum has been written, and releases it only then.

Parameters:
MAX_WORDS, 128, imem depth in 16-bit words. The 8-bit byte-addressed PC gives 256/2 = 128.
AW, 7, imem word-address width; equals clog2(MAX_WORDS).

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  reset; synchronous and active-low.
start  in  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and ERR.
in_data  in  8  stream byte.
in_valid  in  1  in_data is valid.
in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
imem_we  out  1  imem write strobe, one cycle per word.
imem_waddr  out  AW  word address (PC[7:1]).
imem_wdata  out  16  instruction word.
cpu_reset  out  1  active-high reset to the CPU core.
done  out  1  level; image loaded and verified.
error  out  1  level; length or checksum fault.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - Applies mid-load; a partial image is abandoned and no further writes occur.
- States and transitions:
  - IDLE: start -> LEN.
  - LEN: accept byte N.
    - N==0 -> CHK.
    - N>MAX_WORDS -> ERR.
    - otherwise store N, clear word count and checksum, -> HI.
  - HI: accept byte, latch it as hi byte, xor it into checksum, -> LO.
  - LO: accept byte, xor it into checksum, form word {hi,lo}.
    - Next cycle: imem_we=1, imem_waddr=word count, imem_wdata={hi,lo}.
    - Word count increments with the write.
    - Go to HI, or to CHK if this was word N.
  - CHK: accept byte.
    - Equals checksum -> DONE.
    - Otherwise -> ERR.
  - DONE: done=1, cpu_reset=0. start -> LEN, which sets cpu_reset=1 and done=0 on the same edge.
  - ERR: error=1, cpu_reset=1. start -> LEN and clears error.
- in_ready:
  - Registered; 1 exactly in LEN, HI, LO and CHK.
  - Drops to 0 the cycle after the CHK byte is accepted.
  - The source may hold in_valid without loss. No byte is consumed in IDLE, DONE or ERR.
- Write throughput:
  - Write latency is 1 cycle after the LO accept.
  - Back-to-back bytes sustain 1 word per 2 cycles.
  - The write of the last word overlaps the cycle in which CHK becomes ready.
- Arithmetic:
  - Word count has AW+1 bits so N=128 is reachable without wrap.
  - Checksum is an 8-bit XOR of all data bytes only; the length byte is excluded.
- imem_we is strictly a one-cycle pulse. imem_waddr and imem_wdata hold their last values when imem_we=0.
- start is ignored while in LEN/HI/LO/CHK. A load cannot be restarted mid-frame except by reset.
- Gaps are allowed: in_valid low for any number of cycles stalls the FSM with state unchanged.
- cpu_reset deasserts only on the edge entering DONE, never earlier. A failed load never releases the CPU.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants already used by the CPU decode.
  - IMEM_WORDS=128, INSTR_W=16.
  - loader state enum {IDLE, LEN, HI, LO, CHK, DONE, ERR}.
- No sub-module. The FSM, counter and checksum register are small enough to stay in one module.
- The imem itself stays in the CPU; the loader drives only its write port.

Test Plan:
1. Normal load:
   - Stimulus: reset low 2 cycles, release, start, stream 02, 00, 01, B0, 00, B1.
   - Response: exactly two writes, (addr0, 0001) and (addr1, B000). done=1, cpu_reset falls after the B1 byte, error=0.
2. Checksum fault:
   - Stimulus: same stream with final byte B0.
   - Response: both words are written, then error=1, done=0, cpu_reset stays 1, in_ready=0.
3. Length fault and zero length:
   - Stimulus: start, N=81 (hex).
   - Response: ERR with no writes.
   - Stimulus: start, then 00, 00.
   - Response: DONE with no writes.
4. Stalled source:
   - Stimulus: the scenario-1 bytes with in_valid low 3 cycles between each byte.
   - Response: identical writes and final state; no duplicated or dropped bytes.
5. Reset mid-load:
   - Stimulus: start, 03, 80, 00, 10, then reset low 1 cycle.
   - Response: next cycle IDLE, imem_we=0, cpu_reset=1. A new start plus a full 3-word stream then succeeds.
6. Full depth and restart:
   - Stimulus: N=80 (hex) with 256 data bytes of pattern i; then start again from DONE.
   - Response: the last write is at addr 127. On the restart, cpu_reset re-asserts and done=0 on the start edge.
